// File: rtl/acc_fifo_bridge_pkg.sv
// Shared router package: default data/FIFO geometry and pointer-width helper.
package acc_fifo_bridge_pkg;

    localparam int WIDTH_DEF = 128;
    localparam int DEPTH_DEF = 8;

    // Pointer width for a power-of-two depth; a count needs one more bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/acc_fifo_bridge_if.sv
// Router/accelerator handshake bundle for the bridge. The master side is
// whoever issues requests (router and accelerator); the slave is the bridge.
interface acc_fifo_bridge_if
    import acc_fifo_bridge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    // router -> accelerator direction
    logic             put_req;
    logic [WIDTH-1:0] put_data;
    logic             acc_rd_req;
    logic [WIDTH-1:0] acc_rd_data;
    logic             acc_rd_valid;
    logic             to_acc_empty;
    logic             to_acc_full;

    // accelerator -> router direction
    logic             acc_wr_req;
    logic [WIDTH-1:0] acc_wr_data;
    logic             get_req;
    logic [WIDTH-1:0] get_data;
    logic             get_valid;
    logic             from_acc_empty;
    logic             from_acc_full;

    // sticky errors covering both FIFOs
    logic             ovf_err;
    logic             udf_err;

    modport master (
        output put_req, put_data, acc_rd_req, acc_wr_req, acc_wr_data, get_req,
        input  acc_rd_data, acc_rd_valid, to_acc_empty, to_acc_full,
               get_data, get_valid, from_acc_empty, from_acc_full,
               ovf_err, udf_err
    );

    modport slave (
        input  put_req, put_data, acc_rd_req, acc_wr_req, acc_wr_data, get_req,
        output acc_rd_data, acc_rd_valid, to_acc_empty, to_acc_full,
               get_data, get_valid, from_acc_empty, from_acc_full,
               ovf_err, udf_err
    );

endinterface

// File: rtl/acc_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with registered flags, a registered read port and
// one-cycle pulses for rejected pushes/pops. A pop never bypasses a push.
module sync_fifo
    import acc_fifo_bridge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic             push_rej,
    output logic             pop_rej
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             push_ok, pop_ok;

    // Accept/reject decisions, next pointers, count, flags and read port.
    always_comb begin
        // NOTE: every _d gets its default first so no branch can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        push_ok  = push && !full_q  && !flush;
        pop_ok   = pop  && !empty_q && !flush;
        push_rej = push &&  full_q  && !flush;
        pop_rej  = pop  &&  empty_q && !flush;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // State register; reset wins over flush and requests.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; pointers and count alone
        // decide which entries hold live data.
        if (!reset && push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: rtl/acc_fifo_bridge.sv
// Router <-> accelerator bridge: two independent FIFOs plus sticky
// overflow/underflow error bits gathered from both.
module acc_fifo_bridge
    import acc_fifo_bridge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    acc_fifo_bridge_if.slave   bus
);

    logic to_push_rej,   to_pop_rej;
    logic from_push_rej, from_pop_rej;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_to_acc (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (bus.put_req),
        .wr_data  (bus.put_data),
        .pop      (bus.acc_rd_req),
        .rd_data  (bus.acc_rd_data),
        .rd_valid (bus.acc_rd_valid),
        .empty    (bus.to_acc_empty),
        .full     (bus.to_acc_full),
        .push_rej (to_push_rej),
        .pop_rej  (to_pop_rej)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_from_acc (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (bus.acc_wr_req),
        .wr_data  (bus.acc_wr_data),
        .pop      (bus.get_req),
        .rd_data  (bus.get_data),
        .rd_valid (bus.get_valid),
        .empty    (bus.from_acc_empty),
        .full     (bus.from_acc_full),
        .push_rej (from_push_rej),
        .pop_rej  (from_pop_rej)
    );

    // Sticky error accumulation; only flush or reset clears it.
    always_comb begin
        ovf_d = ovf_q | to_push_rej | from_push_rej;
        udf_d = udf_q | to_pop_rej  | from_pop_rej;
        if (flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    // Error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;

endmodule

// File: tb/tb_acc_fifo_bridge.sv
// Directed bench for acc_fifo_bridge: each task drives one scenario and
// compares outputs against hand-computed values at posedge+1.
module tb_acc_fifo_bridge;
    import acc_fifo_bridge_pkg::*;

    typedef logic [WIDTH_DEF-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int vectors     = 0;
    int miscompares = 0;

    acc_fifo_bridge_if #(.WIDTH(WIDTH_DEF)) bus ();

    acc_fifo_bridge #(.WIDTH(WIDTH_DEF), .DEPTH(DEPTH_DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.put_req     = 1'b0;
        bus.put_data    = '0;
        bus.acc_rd_req  = 1'b0;
        bus.acc_wr_req  = 1'b0;
        bus.acc_wr_data = '0;
        bus.get_req     = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        drive_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        word_t exp_data;
        exp_data = '0;
        reset = 1'b1;
        bus.put_req = 1'b1; bus.acc_rd_req = 1'b1; bus.acc_wr_req = 1'b1;
        bus.get_req = 1'b1; flush = 1'b1;
        bus.put_data = word_t'(32'hDEAD); bus.acc_wr_data = word_t'(32'hBEEF);
        tick();
        tick();
        vectors++;
        if ({bus.to_acc_empty, bus.to_acc_full, bus.from_acc_empty, bus.from_acc_full,
             bus.get_valid, bus.acc_rd_valid, bus.ovf_err, bus.udf_err} !== 8'b1010_0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=10100000",
                {bus.to_acc_empty, bus.to_acc_full, bus.from_acc_empty, bus.from_acc_full,
                 bus.get_valid, bus.acc_rd_valid, bus.ovf_err, bus.udf_err});
        end
        vectors++;
        if (bus.get_data !== exp_data || bus.acc_rd_data !== exp_data) begin
            miscompares++;
            $display("FAIL reset_data get=%h rd=%h want=0", bus.get_data, bus.acc_rd_data);
        end
        drive_idle();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_to_acc_basic();
        for (int i = 1; i <= 3; i++) begin
            bus.put_req = 1'b1; bus.put_data = word_t'(i);
            tick();
        end
        bus.put_req = 1'b0;
        vectors++;
        if (bus.to_acc_empty !== 1'b0 || dut.u_to_acc.count_q !== 4'd3) begin
            miscompares++;
            $display("FAIL basic_fill empty=%b count=%0d want empty=0 count=3",
                bus.to_acc_empty, dut.u_to_acc.count_q);
        end
        for (int i = 1; i <= 3; i++) begin
            bus.acc_rd_req = 1'b1;
            tick();
            vectors++;
            if (bus.acc_rd_valid !== 1'b1 || bus.acc_rd_data !== word_t'(i)) begin
                miscompares++;
                $display("FAIL basic_pop%0d valid=%b data=%h want valid=1 data=%h",
                    i, bus.acc_rd_valid, bus.acc_rd_data, word_t'(i));
            end
        end
        bus.acc_rd_req = 1'b0;
        tick();
        vectors++;
        if (bus.acc_rd_valid !== 1'b0 || bus.acc_rd_data !== word_t'(3) || bus.to_acc_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after valid=%b data=%h empty=%b want 0/3/1",
                bus.acc_rd_valid, bus.acc_rd_data, bus.to_acc_empty);
        end
    endtask

    task automatic test_from_acc_fill();
        for (int i = 0; i < 8; i++) begin
            bus.acc_wr_req = 1'b1; bus.acc_wr_data = word_t'(32'h100 + i);
            tick();
            vectors++;
            if (bus.from_acc_full !== (i == 7)) begin
                miscompares++;
                $display("FAIL fill_full%0d got=%b want=%b", i, bus.from_acc_full, (i == 7));
            end
        end
        bus.acc_wr_data = word_t'(32'h1FF);
        tick();
        bus.acc_wr_req = 1'b0;
        vectors++;
        if (bus.ovf_err !== 1'b1 || bus.from_acc_full !== 1'b1 || dut.u_from_acc.count_q !== 4'd8) begin
            miscompares++;
            $display("FAIL fill_ovf ovf=%b full=%b count=%0d want 1/1/8",
                bus.ovf_err, bus.from_acc_full, dut.u_from_acc.count_q);
        end
        vectors++;
        if (bus.to_acc_empty !== 1'b1 || dut.u_to_acc.count_q !== 4'd0) begin
            miscompares++;
            $display("FAIL fill_isolation to_acc_empty=%b count=%0d want 1/0",
                bus.to_acc_empty, dut.u_to_acc.count_q);
        end
        for (int i = 0; i < 8; i++) begin
            bus.get_req = 1'b1;
            tick();
            vectors++;
            if (bus.get_valid !== 1'b1 || bus.get_data !== word_t'(32'h100 + i)) begin
                miscompares++;
                $display("FAIL fill_get%0d valid=%b data=%h want 1/%h",
                    i, bus.get_valid, bus.get_data, word_t'(32'h100 + i));
            end
        end
        bus.get_req = 1'b0;
        tick();
        vectors++;
        if (bus.get_valid !== 1'b0 || bus.from_acc_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drained valid=%b empty=%b want 0/1", bus.get_valid, bus.from_acc_empty);
        end
        do_flush();
        vectors++;
        if (bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_flush_err ovf=%b udf=%b want 0/0", bus.ovf_err, bus.udf_err);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) begin
            bus.put_req = 1'b1; bus.put_data = word_t'(32'h10 + i);
            tick();
        end
        vectors++;
        if (bus.to_acc_full !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpp_full got=%b want=1", bus.to_acc_full);
        end
        bus.put_data = word_t'(32'h99); bus.acc_rd_req = 1'b1;
        tick();
        drive_idle();
        vectors++;
        if (bus.acc_rd_valid !== 1'b1 || bus.acc_rd_data !== word_t'(32'h10) ||
            dut.u_to_acc.count_q !== 4'd7 || bus.to_acc_full !== 1'b0 || bus.ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpp_edge valid=%b data=%h count=%0d full=%b ovf=%b want 1/10/7/0/1",
                bus.acc_rd_valid, bus.acc_rd_data, dut.u_to_acc.count_q, bus.to_acc_full, bus.ovf_err);
        end
        for (int i = 1; i < 8; i++) begin
            bus.acc_rd_req = 1'b1;
            tick();
            vectors++;
            if (bus.acc_rd_valid !== 1'b1 || bus.acc_rd_data !== word_t'(32'h10 + i)) begin
                miscompares++;
                $display("FAIL fullpp_drain%0d valid=%b data=%h want 1/%h",
                    i, bus.acc_rd_valid, bus.acc_rd_data, word_t'(32'h10 + i));
            end
        end
        bus.acc_rd_req = 1'b0;
        tick();
        vectors++;
        if (bus.to_acc_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpp_empty got=%b want=1", bus.to_acc_empty);
        end
        do_flush();
    endtask

    task automatic test_empty();
        bus.get_req = 1'b1;
        tick();
        vectors++;
        if (bus.get_valid !== 1'b0 || bus.udf_err !== 1'b1 || bus.ovf_err !== 1'b0 ||
            bus.get_data !== word_t'(32'h107)) begin
            miscompares++;
            $display("FAIL empty_get valid=%b udf=%b ovf=%b data=%h want 0/1/0/107",
                bus.get_valid, bus.udf_err, bus.ovf_err, bus.get_data);
        end
        bus.acc_wr_req = 1'b1; bus.acc_wr_data = word_t'(32'hAA);
        tick();
        bus.acc_wr_req = 1'b0;
        vectors++;
        if (bus.get_valid !== 1'b0 || dut.u_from_acc.count_q !== 4'd1 || bus.from_acc_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_nobypass valid=%b count=%0d empty=%b want 0/1/0",
                bus.get_valid, dut.u_from_acc.count_q, bus.from_acc_empty);
        end
        tick();
        bus.get_req = 1'b0;
        vectors++;
        if (bus.get_valid !== 1'b1 || bus.get_data !== word_t'(32'hAA)) begin
            miscompares++;
            $display("FAIL empty_followup valid=%b data=%h want 1/aa", bus.get_valid, bus.get_data);
        end
        do_flush();
    endtask

    task automatic test_wrap();
        int push_val;
        int pop_val;
        push_val = 32'h200;
        pop_val  = 32'h200;
        for (int i = 0; i < 4; i++) begin
            bus.put_req = 1'b1; bus.put_data = word_t'(push_val);
            push_val++;
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            bus.put_req = 1'b1; bus.put_data = word_t'(push_val);
            bus.acc_rd_req = 1'b1;
            push_val++;
            tick();
            vectors++;
            if (bus.acc_rd_valid !== 1'b1 || bus.acc_rd_data !== word_t'(pop_val) ||
                dut.u_to_acc.count_q !== 4'd4) begin
                miscompares++;
                $display("FAIL wrap%0d valid=%b data=%h count=%0d want 1/%h/4",
                    i, bus.acc_rd_valid, bus.acc_rd_data, dut.u_to_acc.count_q, word_t'(pop_val));
            end
            pop_val++;
        end
        bus.put_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.acc_rd_req = 1'b1;
            tick();
            vectors++;
            if (bus.acc_rd_data !== word_t'(pop_val)) begin
                miscompares++;
                $display("FAIL wrap_drain%0d data=%h want %h", i, bus.acc_rd_data, word_t'(pop_val));
            end
            pop_val++;
        end
        drive_idle();
        tick();
        do_flush();
    endtask

    task automatic test_flush_reset();
        bus.acc_rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.acc_wr_req = 1'b1; bus.acc_wr_data = word_t'(32'h300 + i);
            tick();
            bus.acc_rd_req = 1'b0;
        end
        flush = 1'b1; bus.get_req = 1'b1; bus.acc_wr_data = word_t'(32'h3FF);
        tick();
        drive_idle();
        vectors++;
        if (bus.from_acc_empty !== 1'b1 || bus.get_valid !== 1'b0 || bus.ovf_err !== 1'b0 ||
            bus.udf_err !== 1'b0 || dut.u_from_acc.count_q !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_state empty=%b valid=%b ovf=%b udf=%b count=%0d want 1/0/0/0/0",
                bus.from_acc_empty, bus.get_valid, bus.ovf_err, bus.udf_err, dut.u_from_acc.count_q);
        end
        bus.put_req = 1'b1; bus.put_data = word_t'(32'h400); bus.get_req = 1'b1;
        tick();
        bus.get_req = 1'b0; bus.put_data = word_t'(32'h401); bus.acc_rd_req = 1'b1;
        tick();
        reset = 1'b1; bus.put_data = word_t'(32'h402);
        tick();
        vectors++;
        if (bus.to_acc_empty !== 1'b1 || bus.acc_rd_valid !== 1'b0 || bus.acc_rd_data !== word_t'(0) ||
            bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid empty=%b valid=%b data=%h ovf=%b udf=%b want 1/0/0/0/0",
                bus.to_acc_empty, bus.acc_rd_valid, bus.acc_rd_data, bus.ovf_err, bus.udf_err);
        end
        reset = 1'b0;
        drive_idle();
        tick();
        vectors++;
        if (bus.to_acc_empty !== 1'b1 || dut.u_to_acc.count_q !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_after empty=%b count=%0d want 1/0", bus.to_acc_empty, dut.u_to_acc.count_q);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_to_acc_basic();
        test_from_acc_fill();
        test_full_push_pop();
        test_empty();
        test_wrap();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
